// File: rtl/updi_pkg.sv
// Shared definitions for the UPDI transmit path: frame field positions,
// serializer state encoding, the SYNCH character and a line-order helper.
// Ports: none (package).
package updi_pkg;

   // Field positions inside a 12-bit pre-framed UPDI character
   localparam int START_IDX  = 11;
   localparam int DATA_MSB   = 10;
   localparam int DATA_LSB   = 3;
   localparam int PARITY_IDX = 2;

   localparam logic [7:0] SYNCH = 8'h55;

   typedef enum logic [1:0] {IDLE, SHIFT, GUARD, DONE} tx_state_e;

   // Bits that follow the start bit, in line order (index 0 goes out first):
   // data LSB first, parity, first stop, second stop.
   function automatic logic [10:0] line_tail(input logic [11:0] frame);
      logic [10:0] t;
      t = '0;
      for (int i = 0; i <= DATA_MSB - DATA_LSB; i++) begin
         t[i] = frame[DATA_LSB + i];
      end
      t[8]  = frame[PARITY_IDX];
      t[9]  = frame[1];
      t[10] = frame[0];
      return t;
   endfunction

endpackage

// File: rtl/updi_baud_tick.sv
// Baud down-counter: reload on restart, count down while enabled, flag the
// last cycle of a bit (bit_end) and the cycle before it (pre_end).
// Ports: clk, rstn (sync active-low), restart, en in; bit_end, pre_end out.
module updi_baud_tick #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic restart,
   input  logic en,
   output logic bit_end,
   output logic pre_end
);

   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] LOAD = BW'(CLK_DIV - 1);

   logic [BW-1:0] cnt;

   // Holds at zero rather than wrapping; the owner reloads it explicitly.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - BW'(1);
      end
   end

   assign bit_end = en && (cnt == '0);
   assign pre_end = en && (cnt == BW'(1));

endmodule

// File: rtl/updi_tx_serializer.sv
// UPDI transmit serializer: shifts 12-bit pre-framed characters (8E2) onto
// the line; 1 cycle from acceptance to start bit; o_ready only in IDLE or the
// final stop-bit cycle of a non-last frame, otherwise upstream holds i_frame.
// Ports: i_clk, i_rstn (sync active-low); i_frame/i_valid/o_ready/i_trans_en
// upstream handshake; o_tx/o_tx_oe pad drive; o_busy, o_done status.
module updi_tx_serializer
   import updi_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int GUARD_BITS = 2
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [11:0] i_frame,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_trans_en,
   output logic        o_tx,
   output logic        o_tx_oe,
   output logic        o_busy,
   output logic        o_done
);

   localparam int GUARD_CYC = GUARD_BITS * CLK_DIV;
   localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
   localparam logic [GW-1:0] GUARD_LOAD = (GUARD_CYC > 0) ? GW'(GUARD_CYC - 1) : '0;

   tx_state_e     state;
   logic [10:0]   sr;
   logic [3:0]    bit_cnt;
   logic [GW-1:0] guard_cnt;
   logic          last;

   logic accept;
   logic bit_end;
   logic pre_end;
   logic baud_restart;

   assign accept = i_valid && o_ready;
   // Reload the baud counter for every new frame and for every bit except
   // the end of the second stop bit.
   assign baud_restart = accept || (bit_end && (bit_cnt != 4'd11));

   updi_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk     (i_clk),
      .rstn    (i_rstn),
      .restart (baud_restart),
      .en      (state == SHIFT),
      .bit_end (bit_end),
      .pre_end (pre_end)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state     <= IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         guard_cnt <= '0;
         last      <= 1'b0;
         o_tx      <= 1'b1;
         o_tx_oe   <= 1'b0;
         o_ready   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         // o_ready is only ever high in IDLE or the final cycle of a
         // non-last frame, so this also covers zero-gap back-to-back frames.
         if (accept) begin
            state   <= SHIFT;
            sr      <= line_tail(i_frame);
            o_tx    <= i_frame[START_IDX];
            o_tx_oe <= 1'b1;
            o_busy  <= 1'b1;
            o_ready <= 1'b0;
            last    <= i_trans_en;
            bit_cnt <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  o_tx    <= 1'b1;
                  o_busy  <= 1'b0;
                  o_ready <= 1'b1;
               end
               SHIFT: begin
                  if (bit_end) begin
                     if (bit_cnt != 4'd11) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        o_tx    <= sr[0];
                        sr      <= {1'b1, sr[10:1]};
                     end else if (!last) begin
                        state   <= IDLE;
                        o_tx    <= 1'b1;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                     end else if (GUARD_CYC > 0) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                        o_tx      <= 1'b1;
                     end else begin
                        state   <= DONE;
                        o_tx    <= 1'b1;
                        o_tx_oe <= 1'b0;
                        o_done  <= 1'b1;
                     end
                  end else begin
                     // Open the handshake for exactly the last stop-bit cycle.
                     o_ready <= pre_end && (bit_cnt == 4'd11) && !last;
                  end
               end
               GUARD: begin
                  if (guard_cnt == '0) begin
                     state   <= DONE;
                     o_tx_oe <= 1'b0;
                     o_done  <= 1'b1;
                  end else begin
                     guard_cnt <= guard_cnt - GW'(1);
                  end
               end
               DONE: begin
                  state   <= IDLE;
                  o_busy  <= 1'b0;
                  o_ready <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
